// File: rtl/mux_arb_pkg.sv
// Purpose : shared types, sizes and arbitration helpers for the 4-requester output arbiter.
// Latency : n/a (types and pure functions only).
// Backpr. : n/a.
// Contents: N_REQ, SEL_W, sel_t, out_state_t, next_rr() (round-robin pick), first_set() (fixed pick).
// Build   : first_set() is used when MUX_4_1_RR_ARBITER_FIXED_PRIO_EN is defined, next_rr() otherwise.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Occupancy of the single output register.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // Round-robin pick: first set bit of valid, scanning upward from last+1 with
  // wrap-around. The 2-bit add wraps naturally; at k == N_REQ the candidate is
  // 'last' itself, so the previous winner is served only when it is alone.
  // With no valid bit set the result is don't-care; 'last' is returned.
  function automatic sel_t next_rr(sel_t last, logic [N_REQ-1:0] valid);
    sel_t win;
    sel_t idx;
    logic found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = sel_t'(last + sel_t'(k));
      if (!found && valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // Fixed-priority pick: lowest set index wins; 0 when nothing is valid.
  function automatic sel_t first_set(logic [N_REQ-1:0] valid);
    sel_t win;
    logic found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && valid[i]) begin
        win   = sel_t'(i);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mux_4_1.sv
// Purpose : generic WIDTH-bit 4:1 data multiplexer.
// Latency : combinational, zero cycles.
// Backpr. : none; pure datapath.
// Ports   : in_0..in_3 [WIDTH] data inputs, sel [2] index, out [WIDTH] selected data.
module mux_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in_0;
    case (sel)
      2'd0:    out = in_0;
      2'd1:    out = in_1;
      2'd2:    out = in_2;
      default: out = in_3;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Purpose : winner selection among four valid bits (round-robin, or fixed priority).
// Latency : combinational, zero cycles.
// Backpr. : none; the caller gates the grant with its own load condition.
// Ports   : req_valid [4], last_sel [2] previous winner in; winner [2], any_valid out.
// Build   : MUX_4_1_RR_ARBITER_FIXED_PRIO_EN selects lowest-index-wins and ignores last_sel.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_valid,
  input  sel_t             last_sel,
  output sel_t             winner,
  output logic             any_valid
);

  assign any_valid = |req_valid;

`ifdef MUX_4_1_RR_ARBITER_FIXED_PRIO_EN
  // Higher indices may starve; last_sel has no meaning here.
  logic unused_last_sel;
  assign unused_last_sel = ^last_sel;
  assign winner          = first_set(req_valid);
`else
  assign winner = next_rr(last_sel, req_valid);
`endif

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Purpose : shares one registered WIDTH-bit output among four valid/ready requesters.
// Latency : requester accepted in cycle N -> out_valid/out_data visible in cycle N+1.
// Backpr. : while out_valid & ~out_ready, req_ready is all zero and the output beat holds.
// Ports   : clk, rst_n (async, active-low); req_valid [4], req_data_0..3 [WIDTH], req_ready [4] one-hot/zero;
//           out_valid, out_data [WIDTH], out_sel [2], out_ready.
// Build   : MUX_4_1_RR_ARBITER_FIXED_PRIO_EN -> fixed priority, no last_sel state; default round-robin.
module mux_4_1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_valid,
  input  logic [WIDTH-1:0] req_data_0,
  input  logic [WIDTH-1:0] req_data_1,
  input  logic [WIDTH-1:0] req_data_2,
  input  logic [WIDTH-1:0] req_data_3,
  output logic [3:0]       req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_sel,
  input  logic             out_ready
);

  out_state_t       state_q;
  out_state_t       state_d;
  sel_t             last_sel;
  sel_t             winner;
  logic             any_valid;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] mux_data;

  // ---------------------------------------------------------------------------
  // Arbitration and data selection
  // ---------------------------------------------------------------------------
  rr_pick4 u_pick (
    .req_valid (req_valid),
    .last_sel  (last_sel),
    .winner    (winner),
    .any_valid (any_valid)
  );

  mux_4_1 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .in_0 (req_data_0),
    .in_1 (req_data_1),
    .in_2 (req_data_2),
    .in_3 (req_data_3),
    .sel  (winner),
    .out  (mux_data)
  );

  // The register may refill in the same cycle it drains, so a steady
  // out_ready keeps one beat per cycle with no bubble.
  assign out_valid = (state_q == ST_FULL);
  assign can_load  = ~out_valid | out_ready;
  assign load      = can_load & any_valid;

  always_comb begin
    req_ready = '0;
    if (load) begin
      req_ready[winner] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output occupancy: EMPTY <-> FULL
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (load) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready && !load) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output payload: only written on an accepted request, otherwise holds
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
    end else if (load) begin
      out_data <= mux_data;
      out_sel  <= winner;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pointer
  // ---------------------------------------------------------------------------
`ifdef MUX_4_1_RR_ARBITER_FIXED_PRIO_EN
  assign last_sel = sel_t'(N_REQ - 1);
`else
  // Reset to the top index so requester 0 is first in line. Advances only on
  // an accepted request, so withdrawn requests and stalls never move it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_sel <= sel_t'(N_REQ - 1);
    end else if (load) begin
      last_sel <= winner;
    end
  end
`endif

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
module tb_mux_4_1_rr_arbiter;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [W-1:0] rd [4];
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  int checks;
  int failures;

  mux_4_1_rr_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data_0 (rd[0]),
    .req_data_1 (rd[1]),
    .req_data_2 (rd[2]),
    .req_data_3 (rd[3]),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference arbitration: the first valid requester met when walking the
  // ring of four starting just after the previous winner.
  function automatic int ref_pick(int last, logic [3:0] v);
`ifdef MUX_4_1_RR_ARBITER_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
`else
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (last + k) % 4;
      if (v[idx]) return idx;
    end
    return last;
`endif
  endfunction

  typedef struct {
    logic [3:0]   valid;
    logic [W-1:0] d0, d1, d2, d3;
    logic         ordy;
    logic [3:0]   exp_rdy;
    logic         exp_vld;
    logic [W-1:0] exp_dat;
    logic [1:0]   exp_sel;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] v, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c,
                              logic [W-1:0] d, logic o, logic [3:0] er, logic ev,
                              logic [W-1:0] ed, logic [1:0] es);
    vec_t t;
    t.valid = v; t.d0 = a; t.d1 = b; t.d2 = c; t.d3 = d; t.ordy = o;
    t.exp_rdy = er; t.exp_vld = ev; t.exp_dat = ed; t.exp_sel = es;
    return t;
  endfunction

  // Model state for the random phase
  int           m_last;
  logic         m_vld;
  logic [W-1:0] m_dat;
  int           m_sel;

  initial begin
    logic [3:0] exp_rdy;
    logic [3:0] nv;
    int         win;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req_valid = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) rd[i] = '0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_sel", 32'(out_sel), 32'd0);
    rst_n = 1'b1;

    // ---------------- table-driven vectors ----------------
`ifdef MUX_4_1_RR_ARBITER_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(4'b1111, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b1, 4'b0001, 1'b1, 8'hA1, 2'd0));
`else
    // full round-robin
    vecs.push_back(mk(4'b1111, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b1, 4'b0001, 1'b1, 8'hA1, 2'd0));
    vecs.push_back(mk(4'b1111, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b1, 4'b0010, 1'b1, 8'hB2, 2'd1));
    vecs.push_back(mk(4'b1111, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b1, 4'b0100, 1'b1, 8'hC3, 2'd2));
    vecs.push_back(mk(4'b1111, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b1, 4'b1000, 1'b1, 8'hD4, 2'd3));
    vecs.push_back(mk(4'b1111, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b1, 4'b0001, 1'b1, 8'hA1, 2'd0));
    // single requester, no bubbles
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(4'b0100, 8'h00, 8'h00, 8'h05, 8'h00, 1'b1, 4'b0100, 1'b1, 8'h05, 2'd2));
    // bring last_sel to 1, then wrap and skip
    vecs.push_back(mk(4'b0010, 8'h00, 8'h11, 8'h00, 8'h00, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1));
    vecs.push_back(mk(4'b1010, 8'h00, 8'h11, 8'h00, 8'h33, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3));
    vecs.push_back(mk(4'b1010, 8'h00, 8'h11, 8'h00, 8'h33, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1));
    vecs.push_back(mk(4'b1010, 8'h00, 8'h11, 8'h00, 8'h33, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3));
    // back-pressure: load 7, stall two cycles, then drain and refill together
    vecs.push_back(mk(4'b0001, 8'h07, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0001, 1'b1, 8'h07, 2'd0));
    vecs.push_back(mk(4'b1111, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b0, 4'b0000, 1'b1, 8'h07, 2'd0));
    vecs.push_back(mk(4'b1111, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b0, 4'b0000, 1'b1, 8'h07, 2'd0));
    vecs.push_back(mk(4'b1111, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b1, 4'b0010, 1'b1, 8'hB2, 2'd1));
    vecs.push_back(mk(4'b0000, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b1, 4'b0000, 1'b0, 8'hB2, 2'd1));
`endif

    @(posedge clk);
    #1;
    foreach (vecs[n]) begin
      req_valid = vecs[n].valid;
      rd[0] = vecs[n].d0; rd[1] = vecs[n].d1; rd[2] = vecs[n].d2; rd[3] = vecs[n].d3;
      out_ready = vecs[n].ordy;
      #2;
      check($sformatf("vec%0d_req_ready", n), 32'(req_ready), 32'(vecs[n].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", n), 32'(out_valid), 32'(vecs[n].exp_vld));
      check($sformatf("vec%0d_out_data", n), 32'(out_data), 32'(vecs[n].exp_dat));
      check($sformatf("vec%0d_out_sel", n), 32'(out_sel), 32'(vecs[n].exp_sel));
    end

    // ---------------- asynchronous reset with a beat held ----------------
    req_valid = 4'b1111;
    rd[0] = 8'h5A; rd[1] = 8'h6B; rd[2] = 8'h7C; rd[3] = 8'h8D;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", 32'(out_valid), 32'd0);
    check("async_reset_out_data", 32'(out_data), 32'd0);
    check("async_reset_out_sel", 32'(out_sel), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #2;
    check("post_reset_req_ready", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("post_reset_out_sel", 32'(out_sel), 32'd0);
    check("post_reset_out_data", 32'(out_data), 32'h5A);

    // ---------------- randomized run against the reference model ----------------
    rst_n = 1'b0;
    req_valid = 4'b0000;
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_last = 3; m_vld = 1'b0; m_dat = '0; m_sel = 0;
    exp_rdy = 4'b0000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // A pending (offered, not accepted) request keeps its payload and may
      // only withdraw; everything else is redrawn.
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && !exp_rdy[i]) begin
          nv[i] = ($urandom_range(7) != 0);
        end else begin
          nv[i] = 1'($urandom_range(1));
          rd[i] = W'($urandom);
        end
      end
      req_valid = nv;
      out_ready = ($urandom_range(3) != 0);
      win = ref_pick(m_last, nv);
      exp_rdy = ((!m_vld || out_ready) && nv != 4'b0000) ? (4'b0001 << win) : 4'b0000;
      #2;
      check($sformatf("rand%0d_req_ready", cyc), 32'(req_ready), 32'(exp_rdy));
      @(posedge clk);
      #1;
      if (exp_rdy != 4'b0000) begin
        m_vld = 1'b1; m_dat = rd[win]; m_sel = win; m_last = win;
      end else if (out_ready) begin
        m_vld = 1'b0;
      end
      check($sformatf("rand%0d_out_valid", cyc), 32'(out_valid), 32'(m_vld));
      check($sformatf("rand%0d_out_data", cyc), 32'(out_data), 32'(m_dat));
      check($sformatf("rand%0d_out_sel", cyc), 32'(out_sel), 32'(m_sel));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
